// File: rtl/mem_request_unit.sv
// mem_request_unit: CPU-to-memory-controller request FSM; define MEM_TIMEOUT_EN to bound the controller wait with a TIMEOUT-cycle limit.
module mem_request_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DWIDTH-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DONE, ERR} state_t;
  state_t state;
  logic addr_ok;
  logic tmo;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  assign addr_ok = cpu_addr[1:0] == 2'b00 && (cpu_addr >> (AWIDTH + 2)) == 32'd0;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || state == ISSUE) cnt <= '0;
    else if (state == WAIT_BUSY || state == WAIT_READY) cnt <= cnt + 1'b1;
  assign tmo = (state == WAIT_BUSY || state == WAIT_READY) && cnt == CW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state        <= IDLE;
      cpu_rdata    <= '0;
      cpu_ack      <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_busy     <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rw       <= 1'b1;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (cpu_req && mem_ready) begin
            cpu_busy <= 1'b1;
            if (addr_ok) begin
              state        <= ISSUE;
              mem_valid    <= 1'b1;
              mem_addr     <= cpu_addr[AWIDTH+1:2];
              mem_rw       <= ~cpu_we;
              mem_wdata    <= cpu_wdata;
              mem_wdata_oe <= cpu_we;
            end else begin
              state   <= ERR;
              cpu_err <= 1'b1;
            end
          end
        ISSUE: begin
          state     <= WAIT_BUSY;
          mem_valid <= 1'b0;
        end
        WAIT_BUSY:
          if (tmo) begin
            state        <= ERR;
            cpu_err      <= 1'b1;
            mem_wdata_oe <= 1'b0;
          end else if (!mem_ready) state <= WAIT_READY;
        WAIT_READY:
          if (mem_ready) begin
            state        <= DONE;
            cpu_ack      <= 1'b1;
            mem_wdata_oe <= 1'b0;
            if (mem_rw) cpu_rdata <= mem_rdata;
          end else if (tmo) begin
            state        <= ERR;
            cpu_err      <= 1'b1;
            mem_wdata_oe <= 1'b0;
          end
        DONE: begin
          state    <= IDLE;
          cpu_ack  <= 1'b0;
          cpu_busy <= 1'b0;
        end
        ERR: begin
          state    <= IDLE;
          cpu_err  <= 1'b0;
          cpu_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: scoreboarded bench driving mem_request_unit against a small busy/ready memory controller model.
module tb_mem_request_unit;
  logic clk = 1'b0;
  logic reset, cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic cpu_ack, cpu_err, cpu_busy, mem_rw, mem_valid, mem_ready, mem_wdata_oe;
  logic [7:0] mem_addr;
  always #5 clk = ~clk;
  mem_request_unit #(.DWIDTH(32), .AWIDTH(8), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
  );
  bit ctrl_ready = 1'b1;
  bit hang = 1'b0;
  bit block = 1'b0;
  int busy_left = 0;
  int lat = 2;
  logic [31:0] mem_q [256];
  bit wr_q [256];
  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'd4) ? 32'hDEADBEEF : {24'hC0FFEE, a};
  endfunction
  assign mem_ready = ctrl_ready & ~block;
  assign mem_rdata = wr_q[mem_addr] ? mem_q[mem_addr] : init_word(mem_addr);
  always @(posedge clk)
    if (mem_valid) begin
      ctrl_ready <= 1'b0;
      busy_left  <= lat;
    end else if (!ctrl_ready && !hang) begin
      if (busy_left <= 1) begin
        ctrl_ready <= 1'b1;
        if (!mem_rw && mem_wdata_oe) begin
          mem_q[mem_addr] <= mem_wdata;
          wr_q[mem_addr]  <= 1'b1;
        end
      end else busy_left <= busy_left - 1;
    end
  typedef struct {bit err; logic [31:0] rdata;} exp_t;
  exp_t sb[$];
  exp_t sb_e;
  int n_checks = 0, n_fail = 0, n_ack = 0, n_err = 0, n_valid = 0;
  logic [31:0] exp_rd;
  always @(negedge clk)
    if (!reset) begin
      if (mem_valid) n_valid++;
      if (cpu_ack) n_ack++;
      if (cpu_err) n_err++;
      if (cpu_ack || cpu_err) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: ack=%b err=%b with nothing expected", cpu_ack, cpu_err);
        end else begin
          sb_e = sb.pop_front();
          if ({cpu_ack, cpu_err} !== {~sb_e.err, sb_e.err} || cpu_rdata !== sb_e.rdata) begin
            n_fail++;
            $display("FAIL sb_result: got ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                     cpu_ack, cpu_err, cpu_rdata, ~sb_e.err, sb_e.err, sb_e.rdata);
          end
        end
      end
    end
  task automatic expect_result(input bit err, input logic [31:0] rd);
    exp_t e;
    e.err = err;
    e.rdata = rd;
    sb.push_back(e);
  endtask
  task automatic send(input bit we, input logic [31:0] a, input logic [31:0] d);
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cpu_ack || cpu_err) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_ack, cpu_err, cpu_busy, mem_valid, mem_rw, mem_wdata_oe} !== 6'b000010) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000010", {cpu_ack, cpu_err, cpu_busy, mem_valid, mem_rw, mem_wdata_oe});
    end
    n_checks++;
    if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    n_checks++;
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_checks++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    exp_rd = 32'h0;
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_load;
    int a0, v0;
    bit ok;
    a0 = n_ack; v0 = n_valid;
    exp_rd = 32'hDEADBEEF;
    expect_result(1'b0, exp_rd);
    send(1'b0, 32'h10, 32'h0);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 8'h04 || mem_rw !== 1'b1 || mem_wdata_oe !== 1'b0) begin
      n_fail++; $display("FAIL load_issue: valid=%b addr=%h rw=%b oe=%b want 1 04 1 0", mem_valid, mem_addr, mem_rw, mem_wdata_oe);
    end
    @(negedge clk);
    n_checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 8'h04 || cpu_busy !== 1'b1) begin
      n_fail++; $display("FAIL load_hold: valid=%b addr=%h busy=%b want 0 04 1", mem_valid, mem_addr, cpu_busy);
    end
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL load_timeout: got no completion want ack"); end
    @(negedge clk);
    n_checks++;
    if (n_ack - a0 !== 1 || n_valid - v0 !== 1 || cpu_busy !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_done: acks=%0d valids=%0d busy=%b rdata=%h want 1 1 0 deadbeef",
                         n_ack - a0, n_valid - v0, cpu_busy, cpu_rdata);
    end
  endtask
  task automatic test_store;
    bit ok, bad;
    expect_result(1'b0, exp_rd);
    send(1'b1, 32'h3FC, 32'h12345678);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 8'hFF || mem_rw !== 1'b0 || mem_wdata_oe !== 1'b1 || mem_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL store_issue: valid=%b addr=%h rw=%b oe=%b data=%h want 1 ff 0 1 12345678",
                         mem_valid, mem_addr, mem_rw, mem_wdata_oe, mem_wdata);
    end
    ok = 1'b0; bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_ack || cpu_err) begin ok = 1'b1; break; end
      if (mem_wdata_oe !== 1'b1 || mem_addr !== 8'hFF || mem_rw !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (!ok || bad) begin n_fail++; $display("FAIL store_wait: done=%b dropped_drive=%b want 1 0", ok, bad); end
    n_checks++;
    if (mem_wdata_oe !== 1'b0) begin n_fail++; $display("FAIL store_oe_done: got %b want 0", mem_wdata_oe); end
    @(negedge clk);
    n_checks++;
    if (!wr_q[255] || mem_q[255] !== 32'h12345678 || cpu_rdata !== exp_rd) begin
      n_fail++; $display("FAIL store_result: written=%b word=%h rdata=%h want 1 12345678 %h", wr_q[255], mem_q[255], cpu_rdata, exp_rd);
    end
  endtask
  task automatic test_bad_addr;
    int e0, v0;
    bit ok;
    e0 = n_err; v0 = n_valid;
    expect_result(1'b1, exp_rd);
    expect_result(1'b1, exp_rd);
    send(1'b0, 32'h2, 32'h0);
    wait_done(ok);
    n_checks++;
    if (!ok || cpu_err !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL bad_misaligned: done=%b err=%b ack=%b want 1 1 0", ok, cpu_err, cpu_ack);
    end
    @(negedge clk);
    send(1'b1, 32'h400, 32'hAAAA5555);
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || n_err - e0 !== 2 || n_valid - v0 !== 0 || cpu_busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_range: done=%b errs=%0d valids=%0d busy=%b want 1 2 0 0", ok, n_err - e0, n_valid - v0, cpu_busy);
    end
  endtask
  task automatic test_back_to_back;
    int a0, e0, v0;
    bit ok;
    a0 = n_ack; e0 = n_err; v0 = n_valid;
    exp_rd = 32'h12345678;
    expect_result(1'b0, exp_rd);
    send(1'b0, 32'h3FC, 32'h0);
    cpu_addr = 32'h2;
    cpu_req = 1'b1;
    wait_done(ok);
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || n_valid - v0 !== 1 || n_err - e0 !== 0 || n_ack - a0 !== 1 || cpu_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL b2b_ignore: done=%b valids=%0d errs=%0d acks=%0d rdata=%h want 1 1 0 1 12345678",
                         ok, n_valid - v0, n_err - e0, n_ack - a0, cpu_rdata);
    end
    expect_result(1'b0, exp_rd);
    send(1'b1, 32'h0, 32'hCAFEF00D);
    wait_done(ok);
    @(negedge clk);
    exp_rd = 32'hCAFEF00D;
    expect_result(1'b0, exp_rd);
    send(1'b0, 32'h0, 32'h0);
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || cpu_rdata !== 32'hCAFEF00D || n_ack - a0 !== 3) begin
      n_fail++; $display("FAIL b2b_store_load: done=%b rdata=%h acks=%0d want 1 cafef00d 3", ok, cpu_rdata, n_ack - a0);
    end
  endtask
  task automatic test_holdoff;
    bit ok, bad;
    exp_rd = 32'hC0FFEE08;
    expect_result(1'b0, exp_rd);
    block = 1'b1;
    cpu_we = 1'b0; cpu_addr = 32'h20; cpu_req = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_valid !== 1'b0 || cpu_busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL holdoff_latch: got accepted while not ready want held off"); end
    block = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 8'h08) begin
      n_fail++; $display("FAIL holdoff_issue: valid=%b addr=%h want 1 08", mem_valid, mem_addr);
    end
    cpu_req = 1'b0;
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || cpu_rdata !== 32'hC0FFEE08) begin
      n_fail++; $display("FAIL holdoff_done: done=%b rdata=%h want 1 c0ffee08", ok, cpu_rdata);
    end
  endtask
`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int k;
    bit ok;
    expect_result(1'b1, exp_rd);
    hang = 1'b1;
    send(1'b1, 32'h80, 32'h0BADF00D);
    @(negedge clk);
    k = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (cpu_err) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || k !== 8 || mem_wdata_oe !== 1'b0 || cpu_rdata !== exp_rd) begin
      n_fail++; $display("FAIL timeout_err: seen=%b cycles=%0d oe=%b rdata=%h want 1 8 0 %h", ok, k, mem_wdata_oe, cpu_rdata, exp_rd);
    end
    hang = 1'b0;
    for (int i = 0; i < 20 && !mem_ready; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cpu_busy !== 1'b0 || mem_ready !== 1'b1 || wr_q[32]) begin
      n_fail++; $display("FAIL timeout_idle: busy=%b ready=%b written=%b want 0 1 0", cpu_busy, mem_ready, wr_q[32]);
    end
  endtask
`else
  task automatic test_no_timeout;
    int e0;
    bit ok;
    e0 = n_err;
    expect_result(1'b0, exp_rd);
    hang = 1'b1;
    send(1'b1, 32'h80, 32'h0BADF00D);
    repeat (100) @(negedge clk);
    n_checks++;
    if (n_err - e0 !== 0 || cpu_busy !== 1'b1 || mem_wdata_oe !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout_wait: errs=%0d busy=%b oe=%b want 0 1 1", n_err - e0, cpu_busy, mem_wdata_oe);
    end
    hang = 1'b0;
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || mem_q[32] !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL no_timeout_done: done=%b word=%h want 1 0badf00d", ok, mem_q[32]);
    end
  endtask
`endif
  task automatic test_reset_mid;
    int a0, e0;
    bit ok, seen, prev;
    a0 = n_ack; e0 = n_err;
    hang = 1'b1;
    send(1'b1, 32'h40, 32'h55AA55AA);
    repeat (3) @(negedge clk);
    n_checks++;
    if (mem_wdata_oe !== 1'b1 || cpu_busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: oe=%b busy=%b want 1 1", mem_wdata_oe, cpu_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cpu_ack, cpu_err, cpu_busy, mem_valid, mem_rw, mem_wdata_oe} !== 6'b000010 ||
        mem_addr !== 8'h00 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: ctrl=%b addr=%h wdata=%h rdata=%h want 000010 00 0 0",
                         {cpu_ack, cpu_err, cpu_busy, mem_valid, mem_rw, mem_wdata_oe}, mem_addr, mem_wdata, cpu_rdata);
    end
    reset = 1'b0;
    exp_rd = 32'hDEADBEEF;
    expect_result(1'b0, exp_rd);
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    hang = 1'b0;
    seen = 1'b0; prev = mem_ready;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid) begin seen = 1'b1; break; end
      prev = mem_ready;
    end
    cpu_req = 1'b0;
    n_checks++;
    if (!seen || !prev) begin n_fail++; $display("FAIL rstmid_reissue: issued=%b ready_before=%b want 1 1", seen, prev); end
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || n_ack - a0 !== 1 || n_err - e0 !== 0 || wr_q[16] || cpu_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rstmid_after: done=%b acks=%0d errs=%0d written=%b rdata=%h want 1 1 0 0 deadbeef",
                         ok, n_ack - a0, n_err - e0, wr_q[16], cpu_rdata);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_load();
    test_store();
    test_bad_addr();
    test_back_to_back();
    test_holdoff();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
